// File: rtl/status_text_buf.sv
// Writable 16x16 status text buffer: mine count, elapsed seconds, game state.
// Define STATUS_TEXT_BLANK_ZERO_EN to blank leading zero digits.
module status_text_buf #(
  parameter int CLK_HZ   = 65_000_000,
  parameter int TIME_MAX = 999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_xy,
  output logic [6:0] char_code,
  input  logic [7:0] mines_left,
  input  logic [1:0] game_state,
  output logic       busy
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [9:0] TMAX = 10'(TIME_MAX);

  typedef enum logic [2:0] {
    S_CLEAR, S_IDLE, S_CONV_M, S_WR_M,
    S_CONV_T, S_WR_T, S_WR_S
  } state_t;

  state_t state, state_nx;

  logic [7:0]    cnt;
  logic          last;
  logic          start;
  logic          we;
  logic [7:0]    waddr;
  logic [6:0]    wdata;
  logic [6:0]    ram [256];

  logic [7:0]    prev_m;
  logic [1:0]    prev_gs;
  logic          dirty;
  logic          dirty_set;

  logic [PW-1:0] presc;
  logic [9:0]    timer;
  logic          playing;
  logic          wrap;
  logic          into_ready;
  logic          timer_chg;

  logic [7:0]    snap_m;
  logic [9:0]    snap_t;
  logic [1:0]    snap_gs;

  logic [9:0]    bin;
  logic [11:0]   bcd;
  logic [11:0]   bcd_adj;
  logic [6:0]    c_h, c_t, c_u;

  function automatic logic [6:0] label(input logic [7:0] a);
    logic [6:0] c;
    case (a)
      8'h00:   c = 7'h4D;
      8'h01:   c = 7'h49;
      8'h02:   c = 7'h4E;
      8'h03:   c = 7'h45;
      8'h04:   c = 7'h53;
      8'h05:   c = 7'h3A;
      8'h10:   c = 7'h54;
      8'h11:   c = 7'h49;
      8'h12:   c = 7'h4D;
      8'h13:   c = 7'h45;
      8'h14:   c = 7'h3A;
      default: c = 7'h20;
    endcase
    return c;
  endfunction

  function automatic logic [6:0] status_char(
    input logic [1:0] gs,
    input logic [3:0] i
  );
    logic [71:0] s;
    int          sh;
    case (gs)
      2'd0:    s = "READY    ";
      2'd1:    s = "PLAYING  ";
      2'd2:    s = "YOU WIN  ";
      default: s = "GAME OVER";
    endcase
    sh = 8 * (8 - int'(i));
    return 7'(s[sh +: 8]);
  endfunction

  // Timer and dirty tracking
  assign playing    = (game_state == 2'd1);
  assign wrap       = playing && (presc == PRESC_MAX);
  assign into_ready = (game_state == 2'd0) && (prev_gs != 2'd0);
  assign timer_chg  = !into_ready && wrap && (timer != TMAX);
  assign dirty_set  = (mines_left != prev_m) ||
                      (game_state != prev_gs) ||
                      timer_chg;

  always_ff @(posedge clk) begin
    prev_m  <= mines_left;
    prev_gs <= game_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      timer <= '0;
    end else if (into_ready) begin
      presc <= '0;
      timer <= '0;
    end else if (playing) begin
      if (wrap) begin
        presc <= '0;
        if (timer != TMAX) timer <= timer + 10'd1;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            dirty <= 1'b1;
    else if (dirty_set) dirty <= 1'b1;
    else if (start)     dirty <= 1'b0;
  end

  // Double-dabble datapath shared by both conversions
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      bcd_adj[4*k +: 4] = (bcd[4*k +: 4] >= 4'd5) ?
                          bcd[4*k +: 4] + 4'd3 :
                          bcd[4*k +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin <= '0;
      bcd <= '0;
    end else if (state == S_CONV_M || state == S_CONV_T) begin
      if (cnt == 8'd0) begin
        bin <= (state == S_CONV_M) ? {2'b00, snap_m} : snap_t;
        bcd <= '0;
      end else begin
        {bcd, bin} <= {bcd_adj, bin} << 1;
      end
    end
  end

  always_comb begin
    c_u = {3'b011, bcd[3:0]};
`ifdef STATUS_TEXT_BLANK_ZERO_EN
    c_h = (bcd[11:8] == 4'd0) ? 7'h20 : {3'b011, bcd[11:8]};
    c_t = (bcd[11:4] == 8'd0) ? 7'h20 : {3'b011, bcd[7:4]};
`else
    c_h = {3'b011, bcd[11:8]};
    c_t = {3'b011, bcd[7:4]};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_m  <= '0;
      snap_t  <= '0;
      snap_gs <= '0;
    end else if (start) begin
      snap_m  <= mines_left;
      snap_t  <= timer;
      snap_gs <= game_state;
    end
  end

  // Writer FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= last ? 8'd0 : cnt + 8'd1;
    end
  end

  always_comb begin
    state_nx = state;
    last     = 1'b0;
    start    = 1'b0;
    we       = 1'b0;
    waddr    = cnt;
    wdata    = 7'h20;
    unique case (state)
      S_CLEAR: begin
        we    = 1'b1;
        wdata = label(cnt);
        if (cnt == 8'd255) begin
          state_nx = S_IDLE;
          last     = 1'b1;
        end
      end
      S_IDLE: begin
        last = 1'b1;
        if (dirty) begin
          start    = 1'b1;
          state_nx = S_CONV_M;
        end
      end
      S_CONV_M, S_CONV_T: begin
        if (cnt == 8'd10) begin
          state_nx = (state == S_CONV_M) ? S_WR_M : S_WR_T;
          last     = 1'b1;
        end
      end
      S_WR_M, S_WR_T: begin
        we    = 1'b1;
        waddr = {(state == S_WR_M) ? 4'd0 : 4'd1,
                 4'd7 + cnt[3:0]};
        unique case (1'b1)
          cnt[1:0] == 2'd0: wdata = c_h;
          cnt[1:0] == 2'd1: wdata = c_t;
          default:          wdata = c_u;
        endcase
        if (cnt == 8'd2) begin
          state_nx = (state == S_WR_M) ? S_CONV_T : S_WR_S;
          last     = 1'b1;
        end
      end
      S_WR_S: begin
        we    = 1'b1;
        waddr = {4'd2, cnt[3:0]};
        wdata = status_char(snap_gs, cnt[3:0]);
        if (cnt == 8'd8) begin
          state_nx = S_IDLE;
          last     = 1'b1;
        end
      end
      default: begin
        state_nx = S_CLEAR;
        last     = 1'b1;
      end
    endcase
  end

  assign busy = (state != S_IDLE);

  // Read-before-write RAM: a same-address read returns the old cell
  always_ff @(posedge clk) begin
    if (we) ram[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) char_code <= '0;
    else     char_code <= ram[char_xy];
  end

endmodule
